filter_accel_mul_arbiter: RTL and testbench

- Shares one unsigned 8x10 multiplier between NUM_REQ requesters inside the filter_accel datapath.
- Arbitration is round-robin. Each granted operand pair is registered before it goes to the multiplier. The product is registered again and returned with the requester ID.
- The multiplier is combinational and sits outside this block. The block drives its operands and samples its product.
- Throughput is one product per cycle. Fixed latency is 2 cycles. A single backpressure input stalls the whole pipeline.

---
 rtl/filter_accel_mul_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_filter_accel_mul_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/filter_accel_mul_arbiter.sv
// filter_accel_mul_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one external
// combinational A_WIDTH x B_WIDTH unsigned multiplier.
// Pipeline: grant -> S1 (operand registers feeding the multiplier)
//                 -> S2 (product register + requester id) -> response port.
// A single downstream backpressure (rsp_valid & ~rsp_ready) freezes both
// stages and suppresses new grants, so results are never lost or duplicated.
// ID_WIDTH must be ceil(log2(NUM_REQ)) and P_WIDTH must be A_WIDTH+B_WIDTH.

module filter_accel_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 10,
  parameter int P_WIDTH  = 18
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic                       ap_idle
);

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic                stall;

  // Unpacked views of the packed operand buses
  logic [A_WIDTH-1:0]  a_arr [NUM_REQ];
  logic [B_WIDTH-1:0]  b_arr [NUM_REQ];

  // Rotated candidate list: candidate k is requester (rr_ptr + k) mod NUM_REQ
  logic [ID_WIDTH:0]   cand_sum   [NUM_REQ];
  logic [ID_WIDTH-1:0] cand_idx   [NUM_REQ];
  logic [NUM_REQ-1:0]  cand_valid;

  logic                grant_any;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_en;
  logic                handshake;

  logic [ID_WIDTH-1:0] rr_ptr_reg;
  logic [ID_WIDTH-1:0] rr_ptr_next;

  // Stage S1: operands held for the multiplier
  logic                s1_valid_reg;
  logic [A_WIDTH-1:0]  s1_a_reg;
  logic [B_WIDTH-1:0]  s1_b_reg;
  logic [ID_WIDTH-1:0] s1_id_reg;

  // Stage S2: registered product and its owner
  logic                rsp_valid_reg;
  logic [P_WIDTH-1:0]  rsp_p_reg;
  logic [ID_WIDTH-1:0] rsp_id_reg;

  // ---------------------------------------------------------------------
  // Operand unpacking and rotated candidate generation
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi] = req_a[gi*A_WIDTH +: A_WIDTH];
      assign b_arr[gi] = req_b[gi*B_WIDTH +: B_WIDTH];

      // rr_ptr and gi are both below NUM_REQ, so one conditional subtract
      // is enough to wrap; the extra sum bit keeps the compare exact.
      assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (ID_WIDTH+1)'(NUM_REQ))
                          ? ID_WIDTH'(cand_sum[gi] - (ID_WIDTH+1)'(NUM_REQ))
                          : cand_sum[gi][ID_WIDTH-1:0];
      assign cand_valid[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Stall: a result is waiting and downstream refuses it
  // ---------------------------------------------------------------------
  assign stall = rsp_valid_reg & ~rsp_ready;

  // Pick the first valid candidate in rotated order (lowest k wins)
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  // Grants are suppressed during reset and while the pipeline is frozen
  assign grant_en = grant_any & ~stall & ~ap_rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_en & (grant_idx == ID_WIDTH'(gi));
    end
  endgenerate

  assign handshake = |(req_valid & req_ready);

  // Advance the round-robin pointer past the requester just served
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (handshake) begin
      if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = grant_idx + ID_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------

  // Round-robin pointer register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Stage S1: capture granted operands; operands only reload on a real
  // handshake so the multiplier inputs stay quiet across bubbles
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_id_reg    <= '0;
    end else if (!stall) begin
      s1_valid_reg <= handshake;
      if (handshake) begin
        s1_a_reg  <= a_arr[grant_idx];
        s1_b_reg  <= b_arr[grant_idx];
        s1_id_reg <= grant_idx;
      end
    end
  end

  // Stage S2: register the multiplier result together with its owner id
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_p_reg     <= '0;
      rsp_id_reg    <= '0;
    end else if (!stall) begin
      rsp_valid_reg <= s1_valid_reg;
      rsp_p_reg     <= mul_dout;
      rsp_id_reg    <= s1_id_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign mul_din0  = s1_a_reg;
  assign mul_din1  = s1_b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_p     = rsp_p_reg;
  assign rsp_id    = rsp_id_reg;

  // Idle only when nothing is asked for and nothing is in flight
  assign ap_idle = ~ap_rst & ~(|req_valid) & ~s1_valid_reg & ~rsp_valid_reg;

endmodule

// File: tb/tb_filter_accel_mul_arbiter.sv
// Testbench for filter_accel_mul_arbiter: cycle-by-cycle vector table plus
// hand-written stall and drain sequences. The shared multiplier is modelled
// here as a combinational product of the DUT's operand outputs.

module tb_filter_accel_mul_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_WIDTH = 2;
  localparam int A_WIDTH  = 8;
  localparam int B_WIDTH  = 10;
  localparam int P_WIDTH  = 18;

  logic                       ap_clk;
  logic                       ap_rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [A_WIDTH-1:0]         mul_din0;
  logic [B_WIDTH-1:0]         mul_din1;
  logic [P_WIDTH-1:0]         mul_dout;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [P_WIDTH-1:0]         rsp_p;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic                       ap_idle;

  int errors = 0;
  int checks = 0;

  filter_accel_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH),
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_p    (rsp_p),
    .rsp_id   (rsp_id),
    .ap_idle  (ap_idle)
  );

  // External shared multiplier
  assign mul_dout = {10'd0, mul_din0} * {8'd0, mul_din1};

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // One row = one clock cycle of stimulus and expected observations
  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [17:0] e_p;
    logic [1:0]  e_id;
    logic        e_idle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] rv, logic rr, logic [3:0] e_rdy,
                              logic e_vld, logic [17:0] e_p, logic [1:0] e_id,
                              logic e_idle);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rr = rr; v.e_rdy = e_rdy;
    v.e_vld = e_vld; v.e_p = e_p; v.e_id = e_id; v.e_idle = e_idle;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester operands (fixed): products r0=14, r1=1000, r2=15, r3=260865
  initial begin
    req_a = {8'd255, 8'd3, 8'd10, 8'd2};
    req_b = {10'd1023, 10'd5, 10'd100, 10'd7};
  end

  int exp_ids [2] = '{1, 2};
  int exp_ps  [2] = '{1000, 15};

  initial begin
    int got;

    ap_rst    = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_din0", 32'(mul_din0), 32'd0);
    chk("rst_din1", 32'(mul_din1), 32'd0);
    chk("rst_rsp_p", 32'(rsp_p), 32'd0);

    //                rst  rv       rr    e_rdy  vld  p        id  idle
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0,      0, 0)); // 0  reset gates ready
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0,      0, 1)); // 1  idle after reset
    vecs.push_back(mk(0, 4'b0100, 1, 4'b0100, 0, 0,      0, 0)); // 2  single request r2
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0,      0, 0)); // 3
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 15,     2, 0)); // 4  3*5
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0,      0, 1)); // 5  idle, ptr=3
    vecs.push_back(mk(0, 4'b1001, 1, 4'b1000, 0, 0,      0, 0)); // 6  wrap: 3 first
    vecs.push_back(mk(0, 4'b0001, 1, 4'b0001, 0, 0,      0, 0)); // 7  then 0
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 260865, 3, 0)); // 8  max operands
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 14,     0, 0)); // 9
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0,      0, 1)); // 10
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0,      0, 0)); // 11 reset before contention
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0001, 0, 0,      0, 0)); // 12 contention 0
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0010, 0, 0,      0, 0)); // 13 1
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 14,     0, 0)); // 14 2
    vecs.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 1000,   1, 0)); // 15 3
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 15,     2, 0)); // 16 stall
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 15,     2, 0)); // 17 stall
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 15,     2, 0)); // 18 stall
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 15,     2, 0)); // 19 release, grant 0
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 260865, 3, 0)); // 20
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 14,     0, 0)); // 21
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0,      0, 1)); // 22
    vecs.push_back(mk(0, 4'b0100, 1, 4'b0100, 0, 0,      0, 0)); // 23 issue r2, ptr->3
    vecs.push_back(mk(1, 4'b1010, 1, 4'b0000, 0, 0,      0, 0)); // 24 reset mid-flight
    vecs.push_back(mk(0, 4'b1010, 1, 4'b0010, 0, 0,      0, 0)); // 25 ptr=0 -> r1, r2 lost
    vecs.push_back(mk(0, 4'b1000, 1, 4'b1000, 0, 0,      0, 0)); // 26
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 1000,   1, 0)); // 27
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 260865, 3, 0)); // 28
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0,      0, 1)); // 29

    foreach (vecs[i]) begin
      ap_rst    = vecs[i].rst;
      req_valid = vecs[i].rv;
      rsp_ready = vecs[i].rr;
      #1;
      $display("row %0d: rst=%0b rv=%b rr=%0b -> rdy=%b vld=%0b p=%0d id=%0d idle=%0b",
               i, ap_rst, req_valid, rsp_ready, req_ready, rsp_valid, rsp_p, rsp_id, ap_idle);
      chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("row%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].e_vld));
      chk($sformatf("row%0d_idle", i),  32'(ap_idle),   32'(vecs[i].e_idle));
      if (vecs[i].e_vld) begin
        chk($sformatf("row%0d_p", i),  32'(rsp_p),  32'(vecs[i].e_p));
        chk($sformatf("row%0d_id", i), 32'(rsp_id), 32'(vecs[i].e_id));
      end
      @(posedge ap_clk);
      #1;
    end

    // Hand sequence: multiplier operands and ready gating under a held stall.
    // State here: ptr=0, pipeline empty.
    ap_rst    = 1'b0;
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    #1;
    chk("h1_ready", 32'(req_ready), 32'b0001);
    @(posedge ap_clk); #1;
    req_valid = 4'b0010;
    #1;
    chk("h2_din0", 32'(mul_din0), 32'd2);
    chk("h2_din1", 32'(mul_din1), 32'd7);
    chk("h2_ready", 32'(req_ready), 32'b0010);
    @(posedge ap_clk); #1;
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("stall %0d: rdy=%b vld=%0b p=%0d id=%0d din0=%0d din1=%0d",
               c, req_ready, rsp_valid, rsp_p, rsp_id, mul_din0, mul_din1);
      chk("hs_ready", 32'(req_ready), 32'b0000);
      chk("hs_valid", 32'(rsp_valid), 32'd1);
      chk("hs_p",     32'(rsp_p),     32'd14);
      chk("hs_id",    32'(rsp_id),    32'd0);
      chk("hs_din0",  32'(mul_din0),  32'd10);
      chk("hs_din1",  32'(mul_din1),  32'd100);
      @(posedge ap_clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("h6_ready", 32'(req_ready), 32'b0100);
    @(posedge ap_clk); #1;
    req_valid = 4'b0000;

    // Drain with a bounded wait: expect id1 then id2, nothing else
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      #1;
      if (rsp_valid) begin
        $display("drain: id=%0d p=%0d", rsp_id, rsp_p);
        chk("drain_id", 32'(rsp_id), 32'(exp_ids[got]));
        chk("drain_p",  32'(rsp_p),  32'(exp_ps[got]));
        got++;
      end
      @(posedge ap_clk); #1;
    end
    chk("drain_count", 32'(got), 32'd2);
    #1;
    chk("final_valid", 32'(rsp_valid), 32'd0);
    chk("final_idle",  32'(ap_idle),   32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
